// File: rtl/comparador_sequencial_param_if.sv
// Handshaked operand/result bundle of the sequential word comparator.
interface comparador_sequencial_param_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, eq, gt, lt
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, eq, gt, lt
    );
endinterface

// File: rtl/comparador_sequencial_param.sv
// Compares WIDTH-bit pairs (unsigned/signed), counts matches and mismatch runs, drives warn/alarm FSM.
// Latency: 1 cycle from accept to eq/gt/lt; single output register, 1 pair/cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result is held stable.
module comparador_sequencial_param #(
    parameter int WIDTH    = 8,
    parameter int CW       = 8,
    parameter int WARN_TH  = 3,
    parameter int ALARM_TH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    comparador_sequencial_param_if.slave bus,
    input  logic                         clr,
    output logic [CW-1:0]                match_cnt,
    output logic [CW-1:0]                miss_run,
    output logic [1:0]                   state,
    output logic                         alarm
);

    if (WIDTH < 1) begin : g_bad_width
        $error("comparador_sequencial_param: WIDTH must be >= 1");
    end
    if (CW < 2 || CW > 30) begin : g_bad_cw
        $error("comparador_sequencial_param: CW must be in 2..30");
    end
    if (WARN_TH < 1 || WARN_TH >= ALARM_TH || ALARM_TH > (2 ** CW) - 1) begin : g_bad_th
        $error("comparador_sequencial_param: need 1 <= WARN_TH < ALARM_TH <= 2^CW-1");
    end

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } res_t;

    typedef enum logic [1:0] {
        S_OK    = 2'b00,
        S_WARN  = 2'b01,
        S_ALARM = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    CNT_SAT  = '1;
    localparam logic [CW-1:0]    WARN_C   = CW'(WARN_TH);
    localparam logic [CW-1:0]    ALARM_C  = CW'(ALARM_TH);

    logic             accept;
    logic             out_valid_q;
    res_t             res_d;
    res_t             res_q;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic [CW-1:0]    match_q;
    logic [CW-1:0]    match_d;
    logic [CW-1:0]    miss_q;
    logic [CW-1:0]    miss_d;
    state_t           state_q;
    state_t           state_d;

    assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_key    = bus.a ^ (bus.signed_mode ? SIGN_BIT : '0);
        b_key    = bus.b ^ (bus.signed_mode ? SIGN_BIT : '0);
        res_d    = '0;
        res_d.eq = (bus.a == bus.b);
        res_d.gt = (a_key > b_key);
        res_d.lt = (a_key < b_key);
    end

    always_comb begin
        match_d = match_q;
        miss_d  = miss_q;
        if (accept) begin
            if (res_d.eq) begin
                if (match_q != CNT_SAT) begin
                    match_d = match_q + CW'(1);
                end
                miss_d = '0;
            end else if (miss_q != CNT_SAT) begin
                miss_d = miss_q + CW'(1);
            end
        end
    end

    // Thresholds are judged on the run length including the pair being accepted.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_OK;
        end else if (accept) begin
            case (state_q)
                S_OK: begin
                    if (miss_d >= WARN_C) begin
                        state_d = S_WARN;
                    end
                end
                S_WARN: begin
                    if (res_d.eq) begin
                        state_d = S_OK;
                    end else if (miss_d >= ALARM_C) begin
                        state_d = S_ALARM;
                    end
                end
                S_ALARM: state_d = S_ALARM;
                default: state_d = S_OK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= '0;
            miss_q  <= '0;
        end else if (clr) begin
            match_q <= '0;
            miss_q  <= '0;
        end else begin
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    // Result flags are forced to zero whenever no result is being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.eq        = res_q.eq;
    assign bus.gt        = res_q.gt;
    assign bus.lt        = res_q.lt;
    assign match_cnt     = match_q;
    assign miss_run      = miss_q;
    assign state         = state_q;
    assign alarm         = (state_q == S_ALARM);

endmodule

// File: tb/tb_comparador_sequencial_param.sv
// Scoreboard bench: directed pairs with hand-computed results, counters and FSM state.
module tb_comparador_sequencial_param;

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct packed {
        logic [2:0] res;
        logic [7:0] mc;
        logic [7:0] mr;
        logic [1:0] st;
        logic       al;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic       clr;
    logic       clr2;
    logic [7:0] match_cnt;
    logic [7:0] miss_run;
    logic [1:0] state;
    logic       alarm;
    logic [1:0] match2;
    logic [1:0] miss2;
    logic [1:0] state2;
    logic       alarm2;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comparador_sequencial_param_if #(.WIDTH(8)) bus ();
    comparador_sequencial_param_if #(.WIDTH(8)) bus2 ();

    comparador_sequencial_param #(.WIDTH(8), .CW(8), .WARN_TH(3), .ALARM_TH(6)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr(clr),
        .match_cnt(match_cnt), .miss_run(miss_run), .state(state), .alarm(alarm)
    );

    comparador_sequencial_param #(.WIDTH(8), .CW(2), .WARN_TH(1), .ALARM_TH(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2), .clr(clr2),
        .match_cnt(match2), .miss_run(miss2), .state(state2), .alarm(alarm2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic sm, input logic c,
                        input logic [2:0] r, input logic [7:0] mc, input logic [7:0] mr,
                        input logic [1:0] st, output int acc_cyc);
        bit ok;
        ok              = 1'b0;
        acc_cyc         = -100;
        bus.in_valid    = 1'b1;
        bus.a           = va;
        bus.b           = vb;
        bus.signed_mode = sm;
        clr             = c;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            clr          = 1'b0;
            return;
        end
        sb.push_back('{r, mc, mr, st, (st == 2'b10)});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        clr     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, mon_e.res});
                check("counters", {13'd0, match_cnt, miss_run, state, alarm},
                      {13'd0, mon_e.mc, mon_e.mr, mon_e.st, mon_e.al});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc[4];
        int sat_exp[6];
        sat_exp = '{1, 2, 3, 3, 0, 0};

        rst_n = 1'b0; rst2_n = 1'b0; clr = 1'b0; clr2 = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.signed_mode = 1'b0; bus2.out_ready = 1'b1;

        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_flags", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
        check("rst_status", {13'd0, match_cnt, miss_run, state, alarm}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1; rst2_n = 1'b1;

        send(8'h5A, 8'h5A, 1'b0, 1'b0, EQ, 8'd1, 8'd0, 2'b00, t);
        send(8'h80, 8'h01, 1'b0, 1'b0, GT, 8'd1, 8'd1, 2'b00, t);
        send(8'h80, 8'h01, 1'b1, 1'b0, LT, 8'd1, 8'd2, 2'b00, t);
        send(8'h33, 8'h33, 1'b0, 1'b0, EQ, 8'd2, 8'd0, 2'b00, t);
        send(8'h10, 8'h20, 1'b0, 1'b0, LT, 8'd2, 8'd1, 2'b00, t);
        send(8'hFF, 8'h01, 1'b1, 1'b0, LT, 8'd2, 8'd2, 2'b00, t);
        send(8'h7F, 8'h80, 1'b1, 1'b0, GT, 8'd2, 8'd3, 2'b01, t);
        send(8'h44, 8'h44, 1'b0, 1'b0, EQ, 8'd3, 8'd0, 2'b00, t);
        send(8'h01, 8'h02, 1'b0, 1'b0, LT, 8'd3, 8'd1, 2'b00, t);
        send(8'h02, 8'h01, 1'b0, 1'b0, GT, 8'd3, 8'd2, 2'b00, t);
        send(8'h03, 8'h01, 1'b0, 1'b0, GT, 8'd3, 8'd3, 2'b01, t);
        send(8'h00, 8'hFF, 1'b0, 1'b0, LT, 8'd3, 8'd4, 2'b01, t);
        send(8'h00, 8'hFF, 1'b1, 1'b0, GT, 8'd3, 8'd5, 2'b01, t);
        send(8'h80, 8'h7F, 1'b0, 1'b0, GT, 8'd3, 8'd6, 2'b10, t);
        send(8'hC3, 8'hC3, 1'b0, 1'b0, EQ, 8'd4, 8'd0, 2'b10, t);
        send(8'h01, 8'h01, 1'b0, 1'b1, EQ, 8'd0, 8'd0, 2'b00, t);
        send(8'h09, 8'h09, 1'b0, 1'b0, EQ, 8'd1, 8'd0, 2'b00, t);
        send(8'hA0, 8'h0A, 1'b0, 1'b0, GT, 8'd1, 8'd1, 2'b00, t);

        // Downstream stall with a new pair waiting.
        bus.out_ready = 1'b0;
        bus.a = 8'h0A; bus.b = 8'hA0; bus.signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_flags", {29'd0, bus.eq, bus.gt, bus.lt}, {29'd0, GT});
            check("stall_counters", {16'd0, match_cnt, miss_run}, {16'd0, 8'd1, 8'd1});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        send(8'h0A, 8'hA0, 1'b0, 1'b0, LT, 8'd1, 8'd2, 2'b00, acc[0]);
        send(8'h05, 8'h05, 1'b0, 1'b0, EQ, 8'd2, 8'd0, 2'b00, acc[1]);
        send(8'h06, 8'h06, 1'b0, 1'b0, EQ, 8'd3, 8'd0, 2'b00, acc[2]);
        send(8'h07, 8'h08, 1'b0, 1'b0, LT, 8'd3, 8'd1, 2'b00, acc[3]);
        bus.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("throughput_gap", acc[i] - acc[i-1], 32'd1);
        end

        @(negedge clk);
        @(negedge clk);
        check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_flags", {29'd0, bus.eq, bus.gt, bus.lt}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("idle_clr", {13'd0, match_cnt, miss_run, state, alarm}, 32'd0);

        // Narrow-counter instance: saturation, then reset mid-stream.
        @(negedge clk);
        bus2.in_valid = 1'b1; bus2.a = 8'h11; bus2.b = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("sat_match", {30'd0, match2}, sat_exp[i]);
            check("sat_eq", {29'd0, bus2.eq, bus2.gt, bus2.lt}, {29'd0, EQ});
        end
        bus2.b = 8'h22;
        @(posedge clk); @(negedge clk);
        check("n_miss1", {27'd0, miss2, state2, alarm2}, {27'd0, 2'd1, 2'b01, 1'b0});
        @(posedge clk); @(negedge clk);
        check("n_miss2", {27'd0, miss2, state2, alarm2}, {27'd0, 2'd2, 2'b10, 1'b1});
        @(posedge clk); @(negedge clk);
        check("n_miss3", {27'd0, miss2, state2, alarm2}, {27'd0, 2'd3, 2'b10, 1'b1});
        @(posedge clk); @(negedge clk);
        check("n_miss_sat", {27'd0, miss2, state2, alarm2}, {27'd0, 2'd3, 2'b10, 1'b1});
        check("n_match_held", {30'd0, match2}, 32'd3);

        rst2_n = 1'b0;
        #1;
        check("mid_rst_valid", {30'd0, bus2.out_valid, bus2.in_ready}, 32'd0);
        check("mid_rst_flags", {29'd0, bus2.eq, bus2.gt, bus2.lt}, 32'd0);
        check("mid_rst_status", {25'd0, match2, miss2, state2, alarm2}, 32'd0);
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
